// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and constant helpers for fifo_stream_reader.
// Optional statistics ports are enabled by defining FIFO_STREAM_READER_STATS_EN.
package fifo_stream_reader_pkg;

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StDrain    = 2'd1,
        StIdleWait = 2'd2
    } state_e;

    // Bits needed to hold any count in 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

    // Bits needed to index 0..depth-1.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // The return pipe only supports BRAM-style latencies of 1 or 2, and the buffer must
    // absorb every outstanding read plus the word being presented.
    function automatic bit params_legal(input int unsigned rd_latency,
                                        input int unsigned obuf_depth);
        return ((rd_latency == 1) || (rd_latency == 2)) && (obuf_depth >= rd_latency + 1);
    endfunction

endpackage

// File: rtl/fifo_stream_reader_obuf.sv
// Small register-based FIFO holding words returned from the sync_fifo until the
// consumer accepts them. Clear has priority over push and pop.
module fifo_stream_reader_obuf
    import fifo_stream_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned OCC_W      = cnt_width(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [OCC_W-1:0]      occ,
    output logic [DATA_WIDTH-1:0] head
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Storage, pointers and occupancy; storage is reset so head reads 0 out of reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= bump(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            if (push && !pop) begin
                occ <= occ + 1'b1;
            end else if (pop && !push) begin
                occ <= occ - 1'b1;
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a sync_fifo read port (rdEn strobe, data RD_LATENCY cycles later) into a
// valid/ready stream, using credit accounting so the output buffer never overflows.
// Define FIFO_STREAM_READER_STATS_EN to add the wordCount/dropCount statistics ports.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned OBUF_DEPTH = RD_LATENCY + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fifoEmpty,
    output logic                  fifoRdEn,
    input  logic [DATA_WIDTH-1:0] fifoRdData,
    input  logic                  flush,
    output logic                  mValid,
    output logic [DATA_WIDTH-1:0] mData,
    input  logic                  mReady,
    output logic                  busy
`ifdef FIFO_STREAM_READER_STATS_EN
    ,
    output logic [31:0]           wordCount,
    output logic [15:0]           dropCount
`endif
);

    localparam int unsigned CNT_W = cnt_width(OBUF_DEPTH);
    localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(OBUF_DEPTH);

    if (!params_legal(RD_LATENCY, OBUF_DEPTH)) begin : g_param_check
        $error("fifo_stream_reader: illegal RD_LATENCY/OBUF_DEPTH combination");
    end

    state_e                state;
    logic [RD_LATENCY-1:0] rd_pipe;
    logic [CNT_W-1:0]      inflight;
    logic [CNT_W-1:0]      occ;
    logic [CNT_W:0]        credit_used;
    logic                  tail;
    logic                  pop;
    logic                  push;

    assign tail = rd_pipe[RD_LATENCY-1];
    assign pop  = mValid & mReady;
    // Returning words are only kept in RUN; a flush in the same cycle discards them.
    assign push = tail & (state == StRun) & ~flush;

    // Outstanding reads are exactly the set bits of the return pipe.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(RD_LATENCY); i++) begin
            inflight = inflight + CNT_W'(rd_pipe[i]);
        end
    end

    // A word popped this cycle frees its slot in time for a read issued now.
    assign credit_used = {1'b0, inflight} + {1'b0, occ} - (CNT_W + 1)'(pop);

    // Gated by reset so no read strobe escapes while the block is held in reset.
    assign fifoRdEn = reset & (state == StRun) & ~fifoEmpty & ~flush
                    & (credit_used < CREDIT_LIMIT);

    // Return pipe: carries each read strobe until its data is on fifoRdData.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe <= RD_LATENCY'({rd_pipe, fifoRdEn});
        end
    end

    // Flush sequencing: drop buffered words, wait out in-flight reads, settle one cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= StRun;
        end else begin
            unique case (state)
                StRun:      if (flush) state <= StDrain;
                StDrain:    if (inflight == '0) state <= StIdleWait;
                StIdleWait: if (!flush) state <= StRun;
                default:    state <= StRun;
            endcase
        end
    end

    fifo_stream_reader_obuf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (OBUF_DEPTH),
        .OCC_W      (CNT_W)
    ) u_obuf (
        .clock (clock),
        .reset (reset),
        .clear (flush),
        .push  (push),
        .wdata (fifoRdData),
        .pop   (pop),
        .occ   (occ),
        .head  (mData)
    );

    assign mValid = (occ != '0);
    assign busy   = (state != StRun) | (inflight != '0) | (occ != '0);

`ifdef FIFO_STREAM_READER_STATS_EN
    logic [CNT_W:0] drop_inc;
    logic [16:0]    drop_sum;

    // Words lost to flush: buffered words (minus one the consumer takes this cycle)
    // plus any word returning from the FIFO while not in RUN or during the flush.
    always_comb begin
        drop_inc = '0;
        if (state == StRun) begin
            if (flush) begin
                drop_inc = {1'b0, occ} - (CNT_W + 1)'(pop) + (CNT_W + 1)'(tail);
            end
        end else begin
            drop_inc = (CNT_W + 1)'(tail);
        end
    end

    assign drop_sum = {1'b0, dropCount} + 17'(drop_inc);

    // Beat counter wraps; drop counter saturates.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wordCount <= '0;
            dropCount <= '0;
        end else begin
            wordCount <= wordCount + 32'(pop);
            dropCount <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader with a behavioural sync_fifo model.
// Define FIFO_STREAM_READER_STATS_EN to also check wordCount/dropCount.
module tb_fifo_stream_reader;

    localparam int DW = 8;
    localparam int RL = 1;
    localparam int OD = RL + 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          fifoEmpty = 1'b1;
    logic          fifoRdEn;
    logic [DW-1:0] fifoRdData;
    logic          flush;
    logic          mValid;
    logic [DW-1:0] mData;
    logic          mReady;
    logic          busy;
`ifdef FIFO_STREAM_READER_STATS_EN
    logic [31:0]   wordCount;
    logic [15:0]   dropCount;
`endif

    fifo_stream_reader #(
        .DATA_WIDTH (DW),
        .RD_LATENCY (RL),
        .OBUF_DEPTH (OD)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .fifoEmpty  (fifoEmpty),
        .fifoRdEn   (fifoRdEn),
        .fifoRdData (fifoRdData),
        .flush      (flush),
        .mValid     (mValid),
        .mData      (mData),
        .mReady     (mReady),
        .busy       (busy)
`ifdef FIFO_STREAM_READER_STATS_EN
        ,
        .wordCount  (wordCount),
        .dropCount  (dropCount)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int underflow = 0;
    int phase_beats = 0;
    int first_cyc = 0;
    int last_cyc  = 0;

    logic [DW-1:0] fq[$];     // contents of the modelled sync_fifo
    logic [DW-1:0] exp_q[$];  // scoreboard: words the stream must still deliver
    logic [DW-1:0] dpipe [RL];
    logic [DW-1:0] mdl_word;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // sync_fifo model: read data appears RL cycles after the strobe; empty is registered.
    always @(posedge clock) begin
        mdl_word = '0;
        if (fifoRdEn) begin
            if (fifoEmpty || fq.size() == 0) underflow++;
            else mdl_word = fq.pop_front();
        end
        for (int i = RL - 1; i > 0; i--) dpipe[i] <= dpipe[i-1];
        dpipe[0] <= mdl_word;
        fifoEmpty <= (fq.size() == 0);
    end
    assign fifoRdData = dpipe[RL-1];

    // Monitor: pops the scoreboard on every accepted beat and checks stall stability.
    logic          stall_prev = 1'b0;
    logic          flush_prev = 1'b0;
    logic [DW-1:0] data_prev  = '0;
    logic [DW-1:0] exp_w;
    always @(negedge clock) begin
        if (!reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && !flush_prev) begin
                chk("stall_hold", {23'd0, mValid, mData}, {23'd0, 1'b1, data_prev});
            end
            if (mValid && mReady) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'(mData), 32'hFFFF_FFFF);
                end else begin
                    exp_w = exp_q.pop_front();
                    chk("beat_data", 32'(mData), 32'(exp_w));
                end
                if (phase_beats == 0) first_cyc = cyc;
                last_cyc = cyc;
                phase_beats++;
            end
            stall_prev = mValid && !mReady;
            data_prev  = mData;
            flush_prev = flush;
        end
    end

    task automatic push_words(input int n, input logic [DW-1:0] base);
        logic [DW-1:0] w;
        for (int i = 0; i < n; i++) begin
            w = base + DW'(i * 7);
            fq.push_back(w);
            exp_q.push_back(w);
        end
    endtask

    task automatic wait_beats(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (phase_beats < n && k < budget) begin
            @(posedge clock); #1;
            k++;
        end
        chk(name, phase_beats, n);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 20) begin
            @(posedge clock); #1;
            k++;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    initial begin
        int bad;
        int lat;
        int rem;
        reset  = 1'b0;
        flush  = 1'b0;
        mReady = 1'b0;

        // Reset hold with a preloaded FIFO: nothing may move.
        @(posedge clock); #1;
        push_words(20, 8'h10);
        bad = 0;
        repeat (30) begin
            @(posedge clock); #1;
            if (fifoRdEn || mValid || busy) bad++;
        end
        chk("reset_quiet", bad, 0);
        chk("reset_mdata", 32'(mData), 32'd0);

        // Release off-edge and stream with continuous ready.
        @(negedge clock);
        reset = 1'b1;
        mReady = 1'b1;
        phase_beats = 0;
        lat = 0;
        while (!mValid && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        chk("first_valid_latency", lat, RL + 1);
        wait_beats(20, 100, "stream_beats");
        chk("stream_no_gaps", last_cyc - first_cyc, 19);
        chk("stream_sb_empty", exp_q.size(), 0);
        wait_idle("stream_idle");

        // Backpressure with ready pattern 1,0,0,1.
        phase_beats = 0;
        push_words(20, 8'h40);
        for (int k = 0; k < 200 && phase_beats < 20; k++) begin
            mReady = ((k % 4) == 0) || ((k % 4) == 3);
            @(posedge clock); #1;
        end
        mReady = 1'b1;
        chk("bp_beats", phase_beats, 20);
        chk("bp_sb_empty", exp_q.size(), 0);
        wait_idle("bp_idle");

        // Empty boundary: one word, a gap, then one more.
        phase_beats = 0;
        push_words(1, 8'hA5);
        wait_beats(1, 20, "gap_first");
        bad = 0;
        repeat (5) begin
            @(posedge clock); #1;
            if (mValid || busy) bad++;
        end
        chk("gap_quiet", bad, 0);
        push_words(1, 8'h5A);
        wait_beats(2, 20, "gap_second");
        repeat (5) @(posedge clock);
        #1;
        chk("gap_total_beats", phase_beats, 2);

        // Flush with a full output buffer: its OD words are lost, the rest stream on.
        phase_beats = 0;
        mReady = 1'b0;
        push_words(20, 8'h80);
        repeat (10) @(posedge clock);
        #1;
        chk("flush_pre_valid", 32'(mValid), 32'd1);
        flush = 1'b1;
        for (int i = 0; i < OD; i++) void'(exp_q.pop_front());
        @(posedge clock); #1;
        flush = 1'b0;
        chk("flush_mvalid_low", 32'(mValid), 32'd0);
        chk("flush_busy", 32'(busy), 32'd1);
        mReady = 1'b1;
        wait_beats(20 - OD, 100, "flush_rest_beats");
        chk("flush_sb_empty", exp_q.size(), 0);
        wait_idle("flush_idle");
`ifdef FIFO_STREAM_READER_STATS_EN
        chk("drop_count", 32'(dropCount), OD);
        chk("word_count", wordCount, 20 + 20 + 2 + (20 - OD));
`endif

        // Asynchronous reset during beat 7: outputs clear at once, FIFO keeps its words.
        phase_beats = 0;
        push_words(20, 8'hC0);
        wait_beats(6, 50, "rst_pre_beats");
        chk("rst_beat7_present", 32'(mValid), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_async_outputs", {28'd0, mValid, busy, fifoRdEn, 1'b0} | 32'(mData), 32'd0);
        exp_q = fq;
        rem = fq.size();
        repeat (3) @(negedge clock);
        reset = 1'b1;
        phase_beats = 0;
        wait_beats(rem, 100, "rst_resume_beats");
        chk("rst_sb_empty", exp_q.size(), 0);
        wait_idle("rst_idle");
`ifdef FIFO_STREAM_READER_STATS_EN
        chk("word_count_after_rst", wordCount, rem);
`endif
        chk("no_underflow", underflow, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
